uart_cmd_ctrl: RTL

//  Sequences the UART receive datapath. Parses rx_dout/rx_vld byte stream into command frames.

---
 rtl/uart_cmd_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_ctrl.sv
// Command-frame parser between uart_rx and the SDRAM test controller; owns baud_sel.
// Latency: cmd_vld / baud_upd / err_* are registered and appear one cycle after the CS/offending byte.
// Backpressure: cmd_vld holds with stable fields until cmd_rdy; bytes arriving meanwhile are dropped (err_ovf).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rx_dout, rx_vld          received byte and its one-cycle strobe
//   cmd_vld, cmd_rdy         command handshake; cmd_wr/cmd_addr/cmd_wdata are its payload
//   baud_sel, baud_upd       baud select register and its one-cycle write pulse
//   err_csum/op/to/ovf       one-cycle error pulses
module uart_cmd_ctrl #(
  parameter int ADDR_BYTES = 3,
  parameter int DATA_BYTES = 2,
  parameter int TIMEOUT    = 100000,
  localparam int ADDR_W    = 8 * ADDR_BYTES,
  localparam int DATA_W    = 8 * DATA_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_dout,
  input  logic              rx_vld,
  output logic              cmd_vld,
  input  logic              cmd_rdy,
  output logic              cmd_wr,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  output logic [1:0]        baud_sel,
  output logic              baud_upd,
  output logic              err_csum,
  output logic              err_op,
  output logic              err_to,
  output logic              err_ovf
);

  localparam int MAX_BYTES = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int CNT_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int TO_W      = $clog2(TIMEOUT + 1);

  localparam logic [7:0] SYNC_BYTE = 8'h55;
  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_BAUD   = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OP,
    S_ADDR,
    S_DATA,
    S_BAUD,
    S_CSUM,
    S_ISSUE
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   byte_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic [7:0]         cs;
  logic               is_wr;
  logic               is_baud;
  logic [ADDR_W-1:0]  addr_sh;
  logic [DATA_W-1:0]  data_sh;
  logic [1:0]         baud_sh;

  logic               in_frame;
  logic               to_hit;
  logic               op_bad;
  logic               csum_ok;
  logic               csum_bad;
  logic               ovf;

  assign cmd_vld  = (state == S_ISSUE);
  assign in_frame = (state != S_IDLE) && (state != S_ISSUE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and per-cycle event flags
  always_comb begin
    state_nx = state;
    op_bad   = 1'b0;
    csum_ok  = 1'b0;
    csum_bad = 1'b0;
    ovf      = 1'b0;
    // A byte arriving on the limit cycle keeps the frame alive.
    to_hit   = in_frame && !rx_vld && (to_cnt == TO_W'(TIMEOUT - 1));

    case (state)
      S_IDLE: begin
        if (rx_vld && rx_dout == SYNC_BYTE) state_nx = S_OP;
      end
      S_OP: begin
        if (rx_vld) begin
          if (rx_dout == OP_WRITE || rx_dout == OP_READ) begin
            state_nx = S_ADDR;
          end else if (rx_dout == OP_BAUD) begin
            state_nx = S_BAUD;
          end else begin
            op_bad   = 1'b1;
            state_nx = S_IDLE;
          end
        end
      end
      S_ADDR: begin
        if (rx_vld && byte_cnt == CNT_W'(ADDR_BYTES - 1)) begin
          state_nx = is_wr ? S_DATA : S_CSUM;
        end
      end
      S_DATA: begin
        if (rx_vld && byte_cnt == CNT_W'(DATA_BYTES - 1)) state_nx = S_CSUM;
      end
      S_BAUD: begin
        if (rx_vld) state_nx = S_CSUM;
      end
      S_CSUM: begin
        if (rx_vld) begin
          if (rx_dout == cs) begin
            csum_ok  = 1'b1;
            state_nx = is_baud ? S_IDLE : S_ISSUE;
          end else begin
            csum_bad = 1'b1;
            state_nx = S_IDLE;
          end
        end
      end
      S_ISSUE: begin
        // Bytes are dropped here, including on the handshake cycle.
        ovf = rx_vld;
        if (cmd_rdy) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    if (to_hit) state_nx = S_IDLE;
  end

  // Frame datapath, shadows and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt  <= '0;
      to_cnt    <= '0;
      cs        <= '0;
      is_wr     <= 1'b0;
      is_baud   <= 1'b0;
      addr_sh   <= '0;
      data_sh   <= '0;
      baud_sh   <= '0;
      cmd_wr    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      baud_sel  <= '0;
      baud_upd  <= 1'b0;
      err_csum  <= 1'b0;
      err_op    <= 1'b0;
      err_to    <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      baud_upd <= 1'b0;
      err_csum <= csum_bad;
      err_op   <= op_bad;
      err_to   <= to_hit;
      err_ovf  <= ovf;

      if (rx_vld || !in_frame || to_hit) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end

      // Counter restarts at every field boundary.
      if (state_nx != state) begin
        byte_cnt <= '0;
      end else if (rx_vld && (state == S_ADDR || state == S_DATA)) begin
        byte_cnt <= byte_cnt + CNT_W'(1);
      end

      if (rx_vld) begin
        case (state)
          S_OP: begin
            cs      <= rx_dout;
            is_wr   <= (rx_dout == OP_WRITE);
            is_baud <= (rx_dout == OP_BAUD);
          end
          S_ADDR: begin
            cs      <= cs ^ rx_dout;
            addr_sh <= (addr_sh << 8) | ADDR_W'(rx_dout);
          end
          S_DATA: begin
            cs      <= cs ^ rx_dout;
            data_sh <= (data_sh << 8) | DATA_W'(rx_dout);
          end
          S_BAUD: begin
            cs      <= cs ^ rx_dout;
            baud_sh <= rx_dout[1:0];
          end
          default: ;
        endcase
      end

      if (csum_ok) begin
        if (is_baud) begin
          baud_sel <= baud_sh;
          baud_upd <= 1'b1;
        end else begin
          cmd_wr   <= is_wr;
          cmd_addr <= addr_sh;
          // Reads leave the previous write data in place.
          if (is_wr) cmd_wdata <= data_sh;
        end
      end
    end
  end

endmodule
